tm_index_sequencer: RTL
=======================

// Module: tm_index_sequencer
// PURPOSE
//  Generates the clause / literal-automaton chunk / clause-chunk index sequence for one TM inference pass.
//  Sits between the top-level start logic and the TM datapath and controller; drives clause_id,
//  la_chunk_id and clause_chunk_id with per-phase valid strobes.
//  Honours a datapath stall, supports abort, and reports completion with a done pulse.
// PARAMETERS
//  CLAUSES        2000  clauses per pass; 1..131072 (17-bit clause_id)
//  LA_CHUNKS      49    LA chunks per clause; 1..131072 (17-bit la_chunk_id)
//  CLAUSE_CHUNKS  63    clause-output chunks summed in class-sum phase; 1..64 (6-bit id)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst_n            in   1   asynchronous active-low reset
//  start            in   1   begin a pass; sampled only in IDLE
//  abort            in   1   synchronous abort; back to IDLE, no done
//  stall            in   1   datapath not ready; freeze counters and FSM
//  clause_id        out  17  current clause index
//  la_chunk_id      out  17  current LA chunk within clause
//  clause_chunk_id  out  6   current clause-output chunk (SUM phase)
//  la_valid         out  1   la_chunk_id/clause_id valid this cycle (LA state, !stall)
//  clause_last      out  1   last LA chunk of current clause issued this cycle
//  sum_valid        out  1   clause_chunk_id valid this cycle (SUM state, !stall)
//  busy             out  1   FSM not in IDLE
//  done             out  1   one-cycle pulse, pass complete
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE; every output, including all counters, is 0.
//  FSM states: IDLE, LA, GAP, FLUSH, SUM, DONE. All outputs are registered.
//  - IDLE:  start=1 -> LA, with clause_id=0 and la_chunk_id=0. start is ignored in any other state.
//  - LA:    la_valid=1 on each cycle with !stall; on such a cycle la_chunk_id increments.
//           When la_chunk_id==LA_CHUNKS-1 and !stall: clause_last=1 that cycle, and
//           clause_id==CLAUSES-1 -> FLUSH, otherwise -> GAP.
//  - GAP:   one bubble cycle; no strobes; clause_id+=1; la_chunk_id=0 -> LA.
//  - FLUSH: one bubble cycle; clause_chunk_id=0 -> SUM.
//  - SUM:   sum_valid=1 on each cycle with !stall; clause_chunk_id increments.
//           clause_chunk_id==CLAUSE_CHUNKS-1 and !stall -> DONE.
//  - DONE:  done=1 for exactly one cycle -> IDLE. Counters hold their final values until the next start.
//  stall:   no effect in IDLE, GAP, FLUSH or DONE. In LA/SUM it holds state, counters and
//           suppresses the strobes (including clause_last).
//  abort:   in any state -> IDLE next cycle, counters cleared, no done. abort has priority over stall and start.
//  Counters never wrap. The terminal compare uses ==, and the terminal value transitions the state.
//  Unstalled latency, with start sampled at edge 0: the first la_valid cycle follows edge 1.
//  done is high in cycle N+1, where N = CLAUSES*LA_CHUNKS + (CLAUSES-1) + 1 + CLAUSE_CHUNKS.
//  CLAUSES=1: no GAP; LA goes straight to FLUSH. LA_CHUNKS=1: clause_last accompanies every la_valid.
// TESTING
//  - Reset: drive rst_n low mid-LA, asynchronously -> all outputs 0 immediately; busy=0.
//  - Small pass, CLAUSES=3 LA_CHUNKS=4 CLAUSE_CHUNKS=2, start pulse, no stall -> 12 la_valid cycles
//    with ids (0,0..3),(1,0..3),(2,0..3); clause_last on la=3; 2 bubbles; 1 flush; sum_valid ids 0,1;
//    done in cycle 18.
//  - Stall: stall=1 for 3 cycles at clause 1, la 2 -> ids frozen; no strobes; done delayed by exactly 3 cycles.
//  - Abort: abort=1 in SUM at clause_chunk_id=1 -> IDLE next cycle, counters 0, done never asserted.
//  - Start while busy: pulse start in LA -> ignored; sequence and done timing unchanged.
//  - Degenerate CLAUSES=1 LA_CHUNKS=1 CLAUSE_CHUNKS=1 -> la_valid+clause_last at cycle 1, FLUSH, sum_valid, done in cycle 4.

Source files
------------

// File: rtl/tm_index_sequencer.sv
// rtl/tm_index_sequencer.sv - clause / LA chunk / clause-chunk index sequencer for one TM inference pass
module tm_index_sequencer #(
  parameter int CLAUSES       = 2000,
  parameter int LA_CHUNKS     = 49,
  parameter int CLAUSE_CHUNKS = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        stall,
  output logic [16:0] clause_id,
  output logic [16:0] la_chunk_id,
  output logic [5:0]  clause_chunk_id,
  output logic        la_valid,
  output logic        clause_last,
  output logic        sum_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LA    = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_SUM   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [16:0] CL_LAST = 17'(CLAUSES - 1);
  localparam logic [16:0] LA_LAST = 17'(LA_CHUNKS - 1);
  localparam logic [5:0]  CC_LAST = 6'(CLAUSE_CHUNKS - 1);

  logic [2:0]  state;
  logic [16:0] cl_cnt;
  logic [16:0] la_cnt;
  logic [5:0]  cc_cnt;

  // Counters point at the next index to issue; the id outputs register the
  // index actually issued, so they line up with the strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cl_cnt          <= '0;
      la_cnt          <= '0;
      cc_cnt          <= '0;
      clause_id       <= '0;
      la_chunk_id     <= '0;
      clause_chunk_id <= '0;
      la_valid        <= 1'b0;
      clause_last     <= 1'b0;
      sum_valid       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      la_valid    <= 1'b0;
      clause_last <= 1'b0;
      sum_valid   <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        state           <= S_IDLE;
        cl_cnt          <= '0;
        la_cnt          <= '0;
        cc_cnt          <= '0;
        clause_id       <= '0;
        la_chunk_id     <= '0;
        clause_chunk_id <= '0;
        busy            <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state           <= S_LA;
              cl_cnt          <= '0;
              la_cnt          <= '0;
              cc_cnt          <= '0;
              clause_id       <= '0;
              la_chunk_id     <= '0;
              clause_chunk_id <= '0;
              busy            <= 1'b1;
            end
          end
          S_LA: begin
            if (!stall) begin
              la_valid    <= 1'b1;
              clause_id   <= cl_cnt;
              la_chunk_id <= la_cnt;
              if (la_cnt == LA_LAST) begin
                clause_last <= 1'b1;
                state       <= (cl_cnt == CL_LAST) ? S_FLUSH : S_GAP;
              end else begin
                la_cnt <= la_cnt + 17'd1;
              end
            end
          end
          S_GAP: begin
            cl_cnt <= cl_cnt + 17'd1;
            la_cnt <= '0;
            state  <= S_LA;
          end
          S_FLUSH: begin
            cc_cnt <= '0;
            state  <= S_SUM;
          end
          S_SUM: begin
            if (!stall) begin
              sum_valid       <= 1'b1;
              clause_chunk_id <= cc_cnt;
              if (cc_cnt == CC_LAST) begin
                state <= S_DONE;
              end else begin
                cc_cnt <= cc_cnt + 6'd1;
              end
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
